// File: rtl/fifo_pkg.sv
// Shared constants and grant encoding for the 8-entry FIFO write scheduler.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned FIFO_ADDR_W = 3;
    localparam int unsigned FIFO_CNT_W  = 4;

    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } gnt_e;

    // Pointers wrap naturally at the 3-bit address width.
    function automatic logic [FIFO_ADDR_W-1:0] ptr_inc(input logic [FIFO_ADDR_W-1:0] p);
        return p + FIFO_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Requester handshakes, consumer pop and memory-side signals of the write scheduler.
interface fifo_wr_sched_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                   req0_valid;
    logic [DATA_WIDTH-1:0]  req0_data;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [DATA_WIDTH-1:0]  req1_data;
    logic                   req1_ready;
    logic                   rd_inc;
    logic                   wclken;
    logic [FIFO_ADDR_W-1:0] waddr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [FIFO_ADDR_W-1:0] raddr;
    logic                   full;
    logic                   empty;
    logic [FIFO_CNT_W-1:0]  count;
    logic                   rd_err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rd_inc,
        input  req0_ready, req1_ready, wclken, waddr, wdata, raddr,
        input  full, empty, count, rd_err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rd_inc,
        output req0_ready, req1_ready, wclken, waddr, wdata, raddr,
        output full, empty, count, rd_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant register updated only on a transfer.
module rr_arb2
    import fifo_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_xfer,
    output logic o_grant0,
    output logic o_grant1
);

    gnt_e r_last_grant;

    always_comb begin
        o_grant0 = 1'b0;
        o_grant1 = 1'b0;
        if (i_valid0 && i_valid1) begin
            if (r_last_grant == GNT_REQ1) begin
                o_grant0 = 1'b1;
            end else begin
                o_grant1 = 1'b1;
            end
        end else if (i_valid0) begin
            o_grant0 = 1'b1;
        end else if (i_valid1) begin
            o_grant1 = 1'b1;
        end
    end

    // Reset to REQ1 so requester 0 wins the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= GNT_REQ1;
        end else if (i_xfer) begin
            r_last_grant <= o_grant1 ? GNT_REQ1 : GNT_REQ0;
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-port scheduler and pointer/occupancy controller for an 8-entry FIFO memory.
module fifo_wr_sched
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input logic            CLK,
    input logic            RST,
    fifo_wr_sched_if.slave bus
);

    localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(DEPTH);

    logic [FIFO_ADDR_W-1:0] r_wptr;
    logic [FIFO_ADDR_W-1:0] r_rptr;
    logic [FIFO_CNT_W-1:0]  r_count;
    logic                   r_rd_err;

    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_ready0;
    logic                   w_ready1;
    logic                   w_xfer0;
    logic                   w_xfer1;
    logic                   w_xfer;
    logic                   w_pop;
    logic [DATA_WIDTH-1:0]  w_wdata;
    logic [FIFO_CNT_W-1:0]  w_count_d;

    rr_arb2 u_arb (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .i_xfer   (w_xfer),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Ready is masked during reset so no handshake completes while RST is high.
    assign w_ready0 = w_grant0 & ~w_full & ~RST;
    assign w_ready1 = w_grant1 & ~w_full & ~RST;
    assign w_xfer0  = bus.req0_valid & w_ready0;
    assign w_xfer1  = bus.req1_valid & w_ready1;
    assign w_xfer   = w_xfer0 | w_xfer1;
    assign w_pop    = bus.rd_inc & ~w_empty;

    always_comb begin
        w_wdata = '0;
        if (w_xfer0) begin
            w_wdata = bus.req0_data;
        end else if (w_xfer1) begin
            w_wdata = bus.req1_data;
        end
    end

    always_comb begin
        w_count_d = r_count;
        unique case ({w_xfer, w_pop})
            2'b10:   w_count_d = r_count + FIFO_CNT_W'(1);
            2'b01:   w_count_d = r_count - FIFO_CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count  <= w_count_d;
            r_rd_err <= bus.rd_inc & w_empty;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.wclken     = w_xfer;
    assign bus.waddr      = r_wptr;
    assign bus.wdata      = w_wdata;
    assign bus.raddr      = r_rptr;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.count      = r_count;
    assign bus.rd_err     = r_rd_err;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed table-driven bench for fifo_wr_sched with a small memory model for read-back.
module tb_fifo_wr_sched;
    import fifo_pkg::*;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       rd;
        logic       rdy0;
        logic       rdy1;
        logic       wen;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] raddr;
        logic [3:0] cnt;
        logic       emp;
        logic       ful;
        logic       err;
        logic       chk_rd;
        logic [7:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_sched_if #(.DATA_WIDTH(8)) bus ();

    fifo_wr_sched #(
        .DATA_WIDTH (8),
        .DEPTH      (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [7:0] mem [8];
    always @(posedge clk) if (bus.wclken) mem[bus.waddr] <= bus.wdata;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input logic rd);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.rd_inc     = rd;
    endtask

    function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic v1,
                                input logic [7:0] d1, input logic rd, input logic rdy0,
                                input logic rdy1, input logic wen, input logic [2:0] wa,
                                input logic [7:0] wd, input logic [2:0] ra,
                                input logic [3:0] cnt, input logic emp, input logic ful,
                                input logic err, input logic crd, input logic [7:0] rdat);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rd = rd;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.wen = wen; v.waddr = wa; v.wdata = wd;
        v.raddr = ra; v.cnt = cnt; v.emp = emp; v.ful = ful; v.err = err;
        v.chk_rd = crd; v.rdata = rdat;
        return v;
    endfunction

    task automatic check_row(input int i, input vec_t v);
        chk($sformatf("row%0d.ready0", i), 32'(bus.req0_ready), 32'(v.rdy0));
        chk($sformatf("row%0d.ready1", i), 32'(bus.req1_ready), 32'(v.rdy1));
        chk($sformatf("row%0d.wclken", i), 32'(bus.wclken), 32'(v.wen));
        chk($sformatf("row%0d.waddr", i), 32'(bus.waddr), 32'(v.waddr));
        chk($sformatf("row%0d.wdata", i), 32'(bus.wdata), 32'(v.wdata));
        chk($sformatf("row%0d.raddr", i), 32'(bus.raddr), 32'(v.raddr));
        chk($sformatf("row%0d.count", i), 32'(bus.count), 32'(v.cnt));
        chk($sformatf("row%0d.empty", i), 32'(bus.empty), 32'(v.emp));
        chk($sformatf("row%0d.full", i), 32'(bus.full), 32'(v.ful));
        chk($sformatf("row%0d.rd_err", i), 32'(bus.rd_err), 32'(v.err));
        if (v.chk_rd) chk($sformatf("row%0d.rdata", i), 32'(mem[bus.raddr]), 32'(v.rdata));
    endtask

    initial begin
        // Contention, mixed write/pop, drain, underflow, write into empty, pointer wrap.
        vecs[0]  = mk(1, 8'hA0, 1, 8'hB0, 0,  1, 0, 1, 0, 8'hA0, 0, 0, 1, 0, 0,  0, 8'h00);
        vecs[1]  = mk(1, 8'hA1, 1, 8'hB0, 0,  0, 1, 1, 1, 8'hB0, 0, 1, 0, 0, 0,  0, 8'h00);
        vecs[2]  = mk(1, 8'hA1, 1, 8'hB1, 0,  1, 0, 1, 2, 8'hA1, 0, 2, 0, 0, 0,  0, 8'h00);
        vecs[3]  = mk(1, 8'hA2, 1, 8'hB1, 0,  0, 1, 1, 3, 8'hB1, 0, 3, 0, 0, 0,  1, 8'hA0);
        vecs[4]  = mk(1, 8'hC0, 0, 8'h00, 1,  1, 0, 1, 4, 8'hC0, 0, 4, 0, 0, 0,  0, 8'h00);
        vecs[5]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 5, 8'h00, 1, 4, 0, 0, 0,  1, 8'hB0);
        vecs[6]  = mk(0, 8'h00, 1, 8'hD0, 1,  0, 1, 1, 5, 8'hD0, 2, 3, 0, 0, 0,  0, 8'h00);
        vecs[7]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 6, 8'h00, 3, 3, 0, 0, 0,  0, 8'h00);
        vecs[8]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 6, 8'h00, 4, 2, 0, 0, 0,  0, 8'h00);
        vecs[9]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 6, 8'h00, 5, 1, 0, 0, 0,  1, 8'hD0);
        vecs[10] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 6, 8'h00, 6, 0, 1, 0, 0,  0, 8'h00);
        vecs[11] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 6, 8'h00, 6, 0, 1, 0, 1,  0, 8'h00);
        vecs[12] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 6, 8'h00, 6, 0, 1, 0, 0,  0, 8'h00);
        vecs[13] = mk(0, 8'h00, 1, 8'h5A, 1,  0, 1, 1, 6, 8'h5A, 6, 0, 1, 0, 0,  0, 8'h00);
        vecs[14] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 7, 8'h00, 6, 1, 0, 0, 1,  1, 8'h5A);
        vecs[15] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 7, 8'h00, 6, 1, 0, 0, 0,  0, 8'h00);
        vecs[16] = mk(1, 8'hE0, 0, 8'h00, 1,  1, 0, 1, 7, 8'hE0, 7, 0, 1, 0, 0,  0, 8'h00);
        vecs[17] = mk(1, 8'hE1, 0, 8'h00, 1,  1, 0, 1, 0, 8'hE1, 7, 1, 0, 0, 1,  0, 8'h00);
        vecs[18] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0,  1, 8'hE1);

        // Reset state, with a requester valid to show the handshake is held off.
        drive(1, 8'h77, 1, 8'h88, 0);
        @(negedge clk);
        chk("rst.ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst.ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst.wclken", 32'(bus.wclken), 32'd0);
        chk("rst.wdata", 32'(bus.wdata), 32'd0);
        chk("rst.count", 32'(bus.count), 32'd0);
        chk("rst.empty", 32'(bus.empty), 32'd1);
        chk("rst.full", 32'(bus.full), 32'd0);
        chk("rst.rd_err", 32'(bus.rd_err), 32'd0);
        chk("rst.raddr", 32'(bus.raddr), 32'd0);
        drive(0, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].rd);
            @(negedge clk);
            check_row(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // Fill and block: start from a clean reset.
        drive(0, 8'h00, 0, 8'h00, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(8'h11 + i), 0, 8'h00, 0);
            @(negedge clk);
            chk($sformatf("fill%0d.ready0", i), 32'(bus.req0_ready), 32'd1);
            chk($sformatf("fill%0d.waddr", i), 32'(bus.waddr), 32'(i));
            @(posedge clk);
            #1;
        end
        drive(1, 8'h19, 0, 8'h00, 0);
        @(negedge clk);
        chk("full.full", 32'(bus.full), 32'd1);
        chk("full.count", 32'(bus.count), 32'd8);
        chk("full.ready0", 32'(bus.req0_ready), 32'd0);
        chk("full.wclken", 32'(bus.wclken), 32'd0);
        @(posedge clk);
        #1;
        drive(1, 8'h19, 0, 8'h00, 1);
        @(negedge clk);
        chk("fullpop.ready0", 32'(bus.req0_ready), 32'd0);
        chk("fullpop.rdata", 32'(mem[bus.raddr]), 32'h11);
        @(posedge clk);
        #1;
        drive(1, 8'h19, 0, 8'h00, 0);
        @(negedge clk);
        chk("after_pop.count", 32'(bus.count), 32'd7);
        chk("after_pop.ready0", 32'(bus.req0_ready), 32'd1);
        chk("after_pop.wclken", 32'(bus.wclken), 32'd1);
        chk("after_pop.waddr", 32'(bus.waddr), 32'd0);
        chk("after_pop.wdata", 32'(bus.wdata), 32'h19);
        @(posedge clk);
        #1;

        // Drain to count 5, then assert reset mid-cycle with a handshake pending.
        drive(0, 8'h00, 0, 8'h00, 1);
        repeat (3) @(posedge clk);
        #1;
        drive(1, 8'h20, 0, 8'h00, 0);
        @(negedge clk);
        chk("pre_rst.count", 32'(bus.count), 32'd5);
        chk("pre_rst.raddr", 32'(bus.raddr), 32'd4);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.count", 32'(bus.count), 32'd0);
        chk("midrst.empty", 32'(bus.empty), 32'd1);
        chk("midrst.waddr", 32'(bus.waddr), 32'd0);
        chk("midrst.raddr", 32'(bus.raddr), 32'd0);
        chk("midrst.wclken", 32'(bus.wclken), 32'd0);
        chk("midrst.ready0", 32'(bus.req0_ready), 32'd0);
        chk("midrst.wdata", 32'(bus.wdata), 32'd0);
        drive(0, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_sched.md
# fifo_wr_sched

Single-clock write scheduler and pointer controller for the 8-entry FIFO memory. It shares the memory write port between two requesters using round-robin arbitration with valid/ready handshakes. It also tracks write/read pointers and occupancy, and drives the memory's write enable, write address, write data and read address. It sits directly in front of the FIFO memory array in a single-clock-domain buffer.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each requester payload and of the memory word
- DEPTH, 8, number of memory entries; fixed at 8, so addresses are 3 bits

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a word to write
- req0_data  in  DATA_WIDTH  requester 0 payload
- req0_ready  out  1  requester 0 word accepted this cycle when valid is also high
- req1_valid  in  1  requester 1 has a word to write
- req1_data  in  DATA_WIDTH  requester 1 payload
- req1_ready  out  1  requester 1 word accepted this cycle when valid is also high
- rd_inc  in  1  consumer pop request
- wclken  out  1  memory write enable
- waddr  out  3  memory write address
- wdata  out  DATA_WIDTH  memory write data
- raddr  out  3  memory read address (head of FIFO)
- full  out  1  count == 8
- empty  out  1  count == 0
- count  out  4  occupancy, 0..8
- rd_err  out  1  one-cycle pulse on pop while empty

## Operation
- Reset values: wptr=0, rptr=0, count=0, empty=1, full=0, rd_err=0, last_grant=1 (requester 0 wins first contention). All ready outputs, wclken and wdata are 0 while RST is high.
- Arbitration is combinational from the current valids and the last_grant register:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = grantN & ~full. A transfer occurs when reqN_valid & reqN_ready.
- On a transfer:
  - wclken=1, waddr=wptr, wdata=reqN_data, all in the same cycle.
  - wptr increments modulo 8 at the edge.
  - last_grant becomes N at the edge.
  - last_grant holds when no transfer occurs.
- When there is no transfer, wclken=0 and wdata=0.
- Pop: when rd_inc & ~empty, rptr increments modulo 8 at the edge. raddr always equals rptr.
- Pop while empty: pointers and count unchanged, rd_err pulses high for 1 cycle (registered).
- Count update:
  - +1 on write only.
  - -1 on valid pop only.
  - Unchanged on simultaneous write and valid pop.
- full and empty are decoded from the registered count.
- Full with simultaneous pop: no write is accepted that cycle, because ready uses the current full. The pop proceeds and count becomes 7.
- Empty with simultaneous write and pop: the write is accepted, the pop is rd_err, and count becomes 1.
- Pointer wrap: 7 -> 0 for both pointers. The full/empty distinction comes from count only.
- RST asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight handshake that cycle is dropped.

## Timing
- Handshake to memory write: 0 cycles. wclken is combinational, and the memory captures the word at the same rising edge.
- Written word visible at raddr/rdata: from the cycle after the write edge when the FIFO was empty.
- empty deasserts, and count updates, 1 cycle after the accepting edge.
- full asserts in the cycle after the 8th accepted write. From that cycle, ready stays low until a pop edge.
- Throughput: 1 write and 1 pop per cycle maximum. Under continuous contention, grants alternate 0,1,0,1.

## Structure
- Shared package fifo_pkg holds:
  - FIFO_DEPTH = 8
  - FIFO_ADDR_W = 3
  - FIFO_CNT_W = 4
  - grant encoding GNT_REQ0 = 0, GNT_REQ1 = 1
- Sub-module rr_arb2: purely the 2-way round-robin grant logic, including the last_grant register and its update-on-transfer input. fifo_wr_sched instantiates it once.
- Pointer, count, error and mux logic stay in fifo_wr_sched.

## Test plan
- Reset check: assert RST mid-stream with count=5 -> count=0, empty=1, wptr=rptr=0, wclken=0 in the same cycle RST rises.
- Contention fairness: both valid continuously with data 0xA0.. and 0xB0.., FIFO not full -> accepted order 0xA0,0xB0,0xA1,0xB1. waddr runs 0,1,2,3.
- Fill and block: 8 writes from req0 with 0x11..0x18 -> full=1, count=8. A 9th valid 0x19 sees ready=0. Pop on the next cycle -> count=7, and 0x19 is written at waddr=0 in the following cycle.
- Simultaneous write and pop at count=3 -> count stays 3. wptr and rptr both advance, with rptr wrapping 7->0 when started at 7.
- Underflow: rd_inc=1 with empty=1 -> rd_err high exactly 1 cycle, rptr unchanged, count=0.
- Write into empty with simultaneous pop: req1 writes 0x5A while rd_inc=1 -> rd_err=1, count=1. raddr data equals 0x5A on the next cycle.
